out_channel_checker: RTL and testbench

- Downstream consumer of the program engine's output channel: accepts output words over a valid/ready handshake, buffers them in a small FIFO, and compares each word in order against a loaded table of expected values.
- Drives `finished` and `success` for the FPGA test top.
- Replaces the ad-hoc end-of-run comparison with a clocked, streaming checker that also reports the first mismatch.

---
 rtl/out_channel_checker.sv | 131 +++++++++++++
 tb/tb_out_channel_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/out_channel_checker.sv
// Streaming checker for the program engine output channel: buffers accepted words in a
// small FIFO and compares them in order against a loaded table of expected values.
//
// state | meaning
// IDLE  | expected table writable, channel closed, waiting for start
// RUN   | accepting words, popping and comparing
// DRAIN | channel closed after programDone, emptying FIFO and compare stage
// DONE  | finished held high, success/mismatchIndex valid
module out_channel_checker #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 3,
    parameter int FifoDepth          = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          expWrite,
    input  logic [7:0]                    expIndex,
    input  logic [MemoryElementWidth-1:0] expData,
    input  logic                          start,
    input  logic                          outValid,
    input  logic [MemoryElementWidth-1:0] outData,
    output logic                          outReady,
    input  logic                          programDone,
    input  logic                          holdCheck,
    output logic                          finished,
    output logic                          success,
    output logic [7:0]                    mismatchIndex,
    output logic [7:0]                    received
);
    localparam int PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int CW = PW + 1;
    localparam int AW = (NOut > 1) ? $clog2(NOut) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [MemoryElementWidth-1:0]   fifo_mem [FifoDepth];
    logic [MemoryElementWidth-1:0]   exp_mem  [NOut];
    logic [PW-1:0]                   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                   count_q;
    logic                            done_q;
    logic [7:0]                      received_q;
    logic                            cmp_valid_q;
    logic [MemoryElementWidth-1:0]   cmp_data_q;
    logic [7:0]                      cmp_cnt_q;
    logic [7:0]                      mismatch_q;

    logic full, active, push, pop, clear, cmp_in_range, cmp_bad;
    logic [MemoryElementWidth-1:0] exp_rd;

    always_comb begin
        full         = (count_q == CW'(FifoDepth));
        active       = (state_q == RUN) || (state_q == DRAIN);
        outReady     = (state_q == RUN) && !done_q && !full;
        push         = outValid && outReady;
        pop          = active && (count_q != '0) && !holdCheck;
        clear        = start && ((state_q == IDLE) || (state_q == DONE));
        cmp_in_range = (cmp_cnt_q < 8'(NOut));
        exp_rd       = exp_mem[cmp_cnt_q[AW-1:0]];
        // Words beyond the table are always bad, whatever their value.
        cmp_bad      = cmp_valid_q && (!cmp_in_range || (cmp_data_q != exp_rd));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (done_q) state_d = DRAIN;
            DRAIN:   if ((count_q == '0) && !cmp_valid_q) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            received_q  <= '0;
            cmp_valid_q <= 1'b0;
            cmp_data_q  <= '0;
            cmp_cnt_q   <= '0;
            mismatch_q  <= 8'hFF;
        end else begin
            state_q <= state_d;
            if (clear) begin
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
                done_q      <= 1'b0;
                received_q  <= '0;
                cmp_valid_q <= 1'b0;
                cmp_cnt_q   <= '0;
                mismatch_q  <= 8'hFF;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push && !pop)      count_q <= count_q + 1'b1;
                else if (pop && !push) count_q <= count_q - 1'b1;
                if (push && (received_q != 8'hFF)) received_q <= received_q + 1'b1;
                if ((state_q == RUN) && programDone) done_q <= 1'b1;
                cmp_valid_q <= pop;
                if (pop) cmp_data_q <= fifo_mem[rd_ptr_q];
                if (cmp_valid_q) begin
                    if (cmp_cnt_q != 8'hFF) cmp_cnt_q <= cmp_cnt_q + 1'b1;
                    if (cmp_bad && (mismatch_q == 8'hFF)) mismatch_q <= cmp_cnt_q;
                end
            end
        end
    end

    // Storage arrays carry no reset; the expected table must survive reset.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q] <= outData;
    end

    always_ff @(posedge clock) begin
        if (!reset && expWrite && (state_q == IDLE) && (expIndex < 8'(NOut)))
            exp_mem[expIndex[AW-1:0]] <= expData;
    end

    always_comb begin
        finished      = (state_q == DONE);
        success       = finished && (mismatch_q == 8'hFF) && (cmp_cnt_q == 8'(NOut));
        mismatchIndex = mismatch_q;
        received      = received_q;
    end
endmodule

// File: tb/tb_out_channel_checker.sv
// Bench for out_channel_checker: directed runs, expected end-of-run results queued by the
// driver and checked by a monitor on each rising edge of finished.
module tb_out_channel_checker;
    localparam int W = 12;

    logic         clock = 1'b0;
    logic         reset, expWrite, start, outValid, programDone, holdCheck;
    logic [7:0]   expIndex;
    logic [W-1:0] expData, outData;
    logic         outReady, finished, success;
    logic [7:0]   mismatchIndex, received;

    typedef struct {
        logic       succ;
        logic [7:0] mi;
        logic [7:0] rc;
    } result_t;

    result_t sb[$];
    int total = 0;
    int bad   = 0;

    out_channel_checker #(.MemoryElementWidth(W), .NOut(3), .FifoDepth(4)) dut (
        .clock(clock), .reset(reset), .expWrite(expWrite), .expIndex(expIndex),
        .expData(expData), .start(start), .outValid(outValid), .outData(outData),
        .outReady(outReady), .programDone(programDone), .holdCheck(holdCheck),
        .finished(finished), .success(success), .mismatchIndex(mismatchIndex),
        .received(received)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: each new finished level consumes one queued expected result.
    initial begin
        logic fin_prev;
        result_t r;
        fin_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (finished && !fin_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_finish", 1, 0);
                end else begin
                    r = sb.pop_front();
                    check("success", int'(success), int'(r.succ));
                    check("mismatchIndex", int'(mismatchIndex), int'(r.mi));
                    check("received", int'(received), int'(r.rc));
                end
            end
            fin_prev = finished;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_finished"}, int'(finished), 0);
        check({tag, "_success"}, int'(success), 0);
        check({tag, "_outReady"}, int'(outReady), 0);
        check({tag, "_mismatchIndex"}, int'(mismatchIndex), 255);
        check({tag, "_received"}, int'(received), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic write_exp(input logic [7:0] idx, input logic [W-1:0] d);
        expWrite = 1'b1; expIndex = idx; expData = d;
        @(negedge clock);
        expWrite = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d);
        int n;
        outValid = 1'b1;
        outData  = d;
        n = 0;
        while (!outReady && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!outReady) check("send_timeout", 0, 1);
        @(negedge clock);
        outValid = 1'b0;
    endtask

    task automatic finish_run();
        int n;
        programDone = 1'b1;
        @(negedge clock);
        programDone = 1'b0;
        n = 0;
        while (!finished && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!finished) check("finish_timeout", 0, 1);
        @(negedge clock);
        @(negedge clock);
    endtask

    initial begin
        logic [W-1:0] wl [4];
        int acc, rdy;
        reset = 1'b1; expWrite = 1'b0; expIndex = '0; expData = '0; start = 1'b0;
        outValid = 1'b0; outData = '0; programDone = 1'b0; holdCheck = 1'b0;
        @(negedge clock);
        do_reset();
        check_reset_outputs("rst");

        write_exp(8'd0, 12'd11);
        write_exp(8'd1, 12'd22);
        write_exp(8'd2, 12'd33);
        write_exp(8'd3, 12'd77);

        // Full match; a table write during RUN must be ignored.
        sb.push_back('{1'b1, 8'd255, 8'd3});
        pulse_start();
        write_exp(8'd1, 12'd99);
        send(12'd11); send(12'd22); send(12'd33);
        finish_run();
        check("finished_level", int'(finished), 1);

        // Re-arm straight from DONE: bad middle word.
        sb.push_back('{1'b0, 8'd1, 8'd3});
        pulse_start();
        check("rearm_finished", int'(finished), 0);
        check("rearm_received", int'(received), 0);
        send(12'd11); send(12'd99); send(12'd33);
        finish_run();

        // Short run.
        sb.push_back('{1'b0, 8'd255, 8'd2});
        pulse_start();
        send(12'd11); send(12'd22);
        finish_run();

        // Extra word.
        sb.push_back('{1'b0, 8'd3, 8'd4});
        pulse_start();
        send(12'd11); send(12'd22); send(12'd33); send(12'd44);
        finish_run();

        // Backpressure: compare stalled, valid held high.
        wl[0] = 12'd11; wl[1] = 12'd22; wl[2] = 12'd33; wl[3] = 12'd44;
        sb.push_back('{1'b0, 8'd3, 8'd4});
        pulse_start();
        holdCheck = 1'b1;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            outValid = 1'b1;
            outData  = wl[(acc < 4) ? acc : 3];
            if (outReady) acc++;
            @(negedge clock);
        end
        check("hold_accepted", acc, 4);
        check("hold_outReady", int'(outReady), 0);
        outValid  = 1'b0;
        holdCheck = 1'b0;
        rdy = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            if (outReady) rdy = 1;
        end
        check("release_outReady", rdy, 1);
        finish_run();

        // Reset mid-run, then rerun with the retained table.
        pulse_start();
        send(12'd11); send(12'd22);
        do_reset();
        check_reset_outputs("midrst");
        sb.push_back('{1'b1, 8'd255, 8'd3});
        pulse_start();
        send(12'd11); send(12'd22); send(12'd33);
        finish_run();

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
